// File: rtl/cal_sat_requant.sv
// Multi-lane requantiser: arithmetic shift (optional round-half-up), optional ReLU, signed saturation IN_W->OUT_W.
// Latency: 2 register stages (S1 shift/round, S2 relu/saturate/output); 1 beat per cycle.
// Backpressure: a single stall enable (!m_valid | m_ready) freezes both stages; s_ready mirrors it.
module cal_sat_requant #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 4,
    parameter int CH      = 4,
    parameter int SHIFT_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SHIFT_W-1:0]    cfg_shift,
    input  logic                  cfg_round,
    input  logic                  cfg_relu,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CH*IN_W-1:0]    s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CH*OUT_W-1:0]   m_data,
    output logic [CH-1:0]         m_sat,
    input  logic                  sat_clr,
    output logic [CNT_W-1:0]      sat_cnt
);

    localparam logic signed [IN_W:0] RND_ONE = {{IN_W{1'b0}}, 1'b1};
    localparam logic [SHIFT_W-1:0]   SH_ONE  = {{(SHIFT_W-1){1'b0}}, 1'b1};
    localparam logic signed [IN_W:0] MAXP    = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINN    = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]     OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic                  adv;
    logic                  v1;
    logic                  relu1;
    logic signed [IN_W:0]  y1      [CH];
    logic signed [IN_W:0]  s1_next [CH];
    logic signed [IN_W:0]  rnd_add;
    logic [CH*OUT_W-1:0]   s2_dat;
    logic [CH-1:0]         s2_sat;
    logic [CNT_W:0]        pop;
    logic [CNT_W:0]        cnt_sum;

    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;

    // One extra bit of headroom so max-positive input plus the rounding term cannot wrap.
    always_comb begin
        rnd_add = '0;
        if (cfg_round && (cfg_shift != '0)) begin
            rnd_add = RND_ONE <<< (cfg_shift - SH_ONE);
        end
        for (int i = 0; i < CH; i++) begin
            s1_next[i] = ($signed({s_data[i*IN_W+IN_W-1], s_data[i*IN_W +: IN_W]}) + rnd_add)
                         >>> cfg_shift;
        end
    end

    // Range check uses the full-width value so large magnitudes never alias into range.
    always_comb begin
        s2_dat = '0;
        s2_sat = '0;
        for (int i = 0; i < CH; i++) begin
            if (relu1 && y1[i][IN_W]) begin
                s2_dat[i*OUT_W +: OUT_W] = '0;
            end else if (y1[i] > MAXP) begin
                s2_dat[i*OUT_W +: OUT_W] = OUT_MAX;
                s2_sat[i]                = 1'b1;
            end else if (y1[i] < MINN) begin
                s2_dat[i*OUT_W +: OUT_W] = OUT_MIN;
                s2_sat[i]                = 1'b1;
            end else begin
                s2_dat[i*OUT_W +: OUT_W] = y1[i][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            relu1   <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                y1[i] <= '0;
            end
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= '0;
        end else if (adv) begin
            v1 <= s_valid;
            if (s_valid) begin
                relu1 <= cfg_relu;
                for (int i = 0; i < CH; i++) begin
                    y1[i] <= s1_next[i];
                end
            end
            m_valid <= v1;
            if (v1) begin
                m_data <= s2_dat;
                m_sat  <= s2_sat;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < CH; i++) begin
            pop = pop + {{CNT_W{1'b0}}, m_sat[i]};
        end
        cnt_sum = {1'b0, sat_cnt} + pop;
    end

    // Counted only on the output handshake so a stalled beat contributes exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (m_valid && m_ready) begin
            sat_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

endmodule
